mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Parametrised multi-cycle MIPS control unit. Owns its own state register and decodes IR opcode/funct into per-cycle datapath controls.
- Adds stall-aware memory handshakes, a bounded memory-wait timeout, and illegal-instruction handling.
- Sits between the IR/ALU-zero datapath outputs and every datapath write enable and mux select.

Parameters:
- MEM_TIMEOUT, 16, max cycles waiting on mem_ready in any one memory state before fault; 0 disables the timeout.
- CNT_W, 5, wait-counter width; must satisfy 2^CNT_W > MEM_TIMEOUT.
- HALT_ON_ILLEGAL, 1, 1: illegal opcode/funct enters ERR; 0: treated as NOP (ID->IF, nothing written).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instruction  in  32  current IR contents.
- zero  in  1  ALU zero flag, combinational from current ALU inputs.
- mem_ready  in  1  memory completes the current read/write this cycle.
- PC_WE  out  1  PC write enable.
- MemIn  out  1  memory address select: 0 PC, 1 ALUOut register.
- Mem_WE  out  1  memory write enable.
- IR_WE  out  1  instruction register write enable.
- Dst  out  2  destination register: 0 rd, 1 rt, 2 r31.
- RegIn  out  2  register write data: 0 ALUOut, 1 MDR, 2 PC.
- Reg_WE  out  1  register file write enable.
- A_WE, B_WE  out  1 each  operand register enables.
- ALUSrcA  out  2  0 PC, 1 A.
- ALUSrcB  out  2  0 B, 1 sext(imm), 2 const 4, 3 sext(imm)<<2.
- ALUOp  out  3  0 ADD, 1 SUB, 2 XOR, 3 SLT.
- PCSrc  out  2  0 ALUOut register, 1 {PC[31:28],addr,00}, 2 ALU result, 3 A.
- state  out  3  current state.
- fault  out  1  sticky error flag.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.

Behaviour:
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, ERR=7. Reset: state=IF, wait counter=0, fault=0.
- All write enables are forced 0 while reset is high. Outputs are combinational from state, opcode, funct, zero and mem_ready.
- Defaults in every state: all write enables 0, selects 0, ALUOp ADD.
- IF:
  - MemIn=0, ALUSrcA=0, ALUSrcB=2, PCSrc=2.
  - IR_WE and PC_WE assert only in the cycle mem_ready=1; that cycle goes to ID. Otherwise hold in IF.
- ID:
  - A_WE=B_WE=1. ALUSrcA=0, ALUSrcB=3 (branch target latched into ALUOut).
  - J: PC_WE=1, PCSrc=1 -> IF.
  - JAL: additionally Reg_WE=1, Dst=2, RegIn=2 -> IF.
  - Illegal opcode/funct: -> ERR if HALT_ON_ILLEGAL, else -> IF.
  - All other legal instructions -> EX.
- Legal set: LW, SW, J, JAL, BEQ, BNE, ADDI, XORI, and R-type ADD, SUB, SLT, JR.
- EX:
  - R-type ADD/SUB/SLT: ALUSrcA=1, ALUSrcB=0, ALUOp per funct -> WB.
  - ADDI/XORI: ALUSrcA=1, ALUSrcB=1, ALUOp ADD/XOR -> WB.
  - LW/SW: ALUSrcA=1, ALUSrcB=1, ADD -> MEM.
  - BEQ/BNE: ALUSrcA=1, ALUSrcB=0, SUB, PCSrc=0. PC_WE = zero (BEQ) or !zero (BNE) -> IF.
  - JR: PC_WE=1, PCSrc=3 -> IF.
- MEM:
  - MemIn=1. SW holds Mem_WE=1 for every MEM cycle.
  - On mem_ready=1: LW -> WB; SW -> IF.
- WB:
  - Reg_WE=1 -> IF.
  - Dst: 0 for R-type; 1 for ADDI, XORI and LW.
  - RegIn: 1 for LW, otherwise 0.
- instr_done pulses on the exit cycle to IF from ID, EX, MEM or WB.
- Wait counter:
  - Clears on any state change; increments each cycle in IF or MEM while mem_ready=0.
  - If MEM_TIMEOUT!=0 and counter reaches MEM_TIMEOUT with mem_ready still 0 -> ERR.
  - mem_ready=1 in the same cycle as the limit wins: the memory access completes.
- ERR: all enables 0, fault=1; ERR and fault persist until reset.
- Reset mid-instruction: immediately IF; no partial write may complete after reset asserts.
- Zero-wait latencies: J/JAL 2, BEQ/BNE/JR 3, R-type/ADDI/XORI/SW 4, LW 5 cycles.

Test Plan:
- ADD $3,$1,$2 (0x00221820), mem_ready=1 -> states IF,ID,EX,WB. WB: Reg_WE=1, Dst=0, RegIn=0. EX: ALUOp=0. instr_done in WB only.
- LW $5,8($4) (0x8C850008), mem_ready low for 3 MEM cycles -> MEM held 4 cycles, MemIn=1, Mem_WE=0 throughout, then WB with Dst=1, RegIn=1; 8 cycles total.
- BEQ with zero=1, then BNE with zero=1 -> BEQ: PC_WE=1, PCSrc=0 in EX. BNE: PC_WE=0. Each returns to IF after 3 cycles.
- JAL 0x0C000010 -> ID: PC_WE=1, PCSrc=1, Reg_WE=1, Dst=2, RegIn=2; next state IF.
- SW with mem_ready stuck 0, MEM_TIMEOUT=16 -> Mem_WE=1 for 16 MEM cycles, then ERR, fault=1, all enables 0; reset returns to IF with fault=0.
- Opcode 0x3F: HALT_ON_ILLEGAL=1 -> ERR after ID. HALT_ON_ILLEGAL=0 -> IF after ID, no Reg_WE/Mem_WE pulse.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: decodes the IR opcode/funct into per-cycle
// datapath controls, waits on memory handshakes with a bounded timeout, and
// halts in a sticky error state on illegal instructions or memory faults.
module mc_control_fsm #(
   parameter int MEM_TIMEOUT     = 16,
   parameter int CNT_W           = 5,
   parameter bit HALT_ON_ILLEGAL = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        PC_WE,
   output logic        MemIn,
   output logic        Mem_WE,
   output logic        IR_WE,
   output logic [1:0]  Dst,
   output logic [1:0]  RegIn,
   output logic        Reg_WE,
   output logic        A_WE,
   output logic        B_WE,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [2:0]  ALUOp,
   output logic [1:0]  PCSrc,
   output logic [2:0]  state,
   output logic        fault,
   output logic        instr_done
);

   localparam logic [2:0] S_IF  = 3'd0;
   localparam logic [2:0] S_ID  = 3'd1;
   localparam logic [2:0] S_EX  = 3'd2;
   localparam logic [2:0] S_MEM = 3'd3;
   localparam logic [2:0] S_WB  = 3'd4;
   localparam logic [2:0] S_ERR = 3'd7;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_XORI = 6'h0E;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_XOR = 3'd2;
   localparam logic [2:0] ALU_SLT = 3'd3;

   // Counter value on the last allowed wait cycle; only meaningful when the timeout is enabled.
   localparam int               TO_LIM_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
   localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TO_LIM_I);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fault_q, fault_d;

   logic [5:0] opcode, funct;
   logic       is_r, is_jr, is_lw, is_sw, legal;
   logic       mem_state, timeout_hit;
   logic       pc_we_r, mem_we_r, ir_we_r, reg_we_r, a_we_r, b_we_r;
   logic       unused_instr;

   assign opcode       = instruction[31:26];
   assign funct        = instruction[5:0];
   assign unused_instr = ^instruction[25:6];

   assign is_r  = (opcode == OP_R);
   assign is_jr = is_r && (funct == FN_JR);
   assign is_lw = (opcode == OP_LW);
   assign is_sw = (opcode == OP_SW);

   // Instruction legality from opcode and, for R-type, funct.
   always_comb begin
      legal = 1'b0;
      case (opcode)
         OP_R:    legal = (funct == FN_ADD) || (funct == FN_SUB) ||
                          (funct == FN_SLT) || (funct == FN_JR);
         OP_J, OP_JAL, OP_BEQ, OP_BNE,
         OP_ADDI, OP_XORI, OP_LW, OP_SW: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   // The limit only trips while memory is still not ready; a same-cycle ready wins.
   assign mem_state   = (state_q == S_IF) || (state_q == S_MEM);
   assign timeout_hit = (MEM_TIMEOUT != 0) && mem_state && !mem_ready && (cnt_q == TO_LIM);

   // Next-state and per-state control decode.
   always_comb begin
      state_d  = state_q;
      pc_we_r  = 1'b0;
      mem_we_r = 1'b0;
      ir_we_r  = 1'b0;
      reg_we_r = 1'b0;
      a_we_r   = 1'b0;
      b_we_r   = 1'b0;
      MemIn    = 1'b0;
      Dst      = 2'd0;
      RegIn    = 2'd0;
      ALUSrcA  = 2'd0;
      ALUSrcB  = 2'd0;
      ALUOp    = ALU_ADD;
      PCSrc    = 2'd0;
      case (state_q)
         S_IF: begin
            ALUSrcB = 2'd2;
            PCSrc   = 2'd2;
            if (mem_ready) begin
               ir_we_r = 1'b1;
               pc_we_r = 1'b1;
               state_d = S_ID;
            end else if (timeout_hit) begin
               state_d = S_ERR;
            end
         end
         S_ID: begin
            a_we_r  = 1'b1;
            b_we_r  = 1'b1;
            ALUSrcB = 2'd3;
            if (!legal) begin
               state_d = HALT_ON_ILLEGAL ? S_ERR : S_IF;
            end else if (opcode == OP_J) begin
               pc_we_r = 1'b1;
               PCSrc   = 2'd1;
               state_d = S_IF;
            end else if (opcode == OP_JAL) begin
               pc_we_r  = 1'b1;
               PCSrc    = 2'd1;
               reg_we_r = 1'b1;
               Dst      = 2'd2;
               RegIn    = 2'd2;
               state_d  = S_IF;
            end else begin
               state_d = S_EX;
            end
         end
         S_EX: begin
            if (is_jr) begin
               pc_we_r = 1'b1;
               PCSrc   = 2'd3;
               state_d = S_IF;
            end else if (is_r) begin
               ALUSrcA = 2'd1;
               ALUSrcB = 2'd0;
               ALUOp   = (funct == FN_SUB) ? ALU_SUB :
                         (funct == FN_SLT) ? ALU_SLT : ALU_ADD;
               state_d = S_WB;
            end else if (opcode == OP_ADDI || opcode == OP_XORI) begin
               ALUSrcA = 2'd1;
               ALUSrcB = 2'd1;
               ALUOp   = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
               state_d = S_WB;
            end else if (is_lw || is_sw) begin
               ALUSrcA = 2'd1;
               ALUSrcB = 2'd1;
               state_d = S_MEM;
            end else begin
               // Branches: compare A and B; the target already sits in ALUOut.
               ALUSrcA = 2'd1;
               ALUSrcB = 2'd0;
               ALUOp   = ALU_SUB;
               PCSrc   = 2'd0;
               pc_we_r = (opcode == OP_BEQ) ? zero : !zero;
               state_d = S_IF;
            end
         end
         S_MEM: begin
            MemIn    = 1'b1;
            mem_we_r = is_sw;
            if (mem_ready) begin
               state_d = is_lw ? S_WB : S_IF;
            end else if (timeout_hit) begin
               state_d = S_ERR;
            end
         end
         S_WB: begin
            reg_we_r = 1'b1;
            Dst      = is_r ? 2'd0 : 2'd1;
            RegIn    = is_lw ? 2'd1 : 2'd0;
            state_d  = S_IF;
         end
         S_ERR:   state_d = S_ERR;
         default: state_d = S_ERR;
      endcase
   end

   // Wait counter restarts on every state change and counts stalled memory cycles.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (mem_state && !mem_ready) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign fault_d = fault_q || (state_d == S_ERR);

   // State, wait counter and sticky fault registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IF;
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   // Write enables are suppressed while reset is held so no partial write slips through.
   assign PC_WE   = pc_we_r  & ~reset;
   assign Mem_WE  = mem_we_r & ~reset;
   assign IR_WE   = ir_we_r  & ~reset;
   assign Reg_WE  = reg_we_r & ~reset;
   assign A_WE    = a_we_r   & ~reset;
   assign B_WE    = b_we_r   & ~reset;

   assign state      = state_q;
   assign fault      = fault_q;
   assign instr_done = (state_q == S_ID || state_q == S_EX || state_q == S_MEM ||
                        state_q == S_WB) && (state_d == S_IF);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: one halting instance and one NOP-on-illegal
// instance share the same stimulus.
module tb_mc_control_fsm;

   logic        clk = 1'b0;
   logic        reset, zero, mem_ready;
   logic [31:0] instruction;

   logic       PC_WE_h, MemIn_h, Mem_WE_h, IR_WE_h, Reg_WE_h, A_WE_h, B_WE_h, fault_h, done_h;
   logic [1:0] Dst_h, RegIn_h, ALUSrcA_h, ALUSrcB_h, PCSrc_h;
   logic [2:0] ALUOp_h, state_h;

   logic       PC_WE_n, MemIn_n, Mem_WE_n, IR_WE_n, Reg_WE_n, A_WE_n, B_WE_n, fault_n, done_n;
   logic [1:0] Dst_n, RegIn_n, ALUSrcA_n, ALUSrcB_n, PCSrc_n;
   logic [2:0] ALUOp_n, state_n;

   int n_run  = 0;
   int n_fail = 0;

   mc_control_fsm #(.MEM_TIMEOUT(16), .CNT_W(5), .HALT_ON_ILLEGAL(1'b1)) dut_h (
      .clk(clk), .reset(reset), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
      .PC_WE(PC_WE_h), .MemIn(MemIn_h), .Mem_WE(Mem_WE_h), .IR_WE(IR_WE_h), .Dst(Dst_h),
      .RegIn(RegIn_h), .Reg_WE(Reg_WE_h), .A_WE(A_WE_h), .B_WE(B_WE_h), .ALUSrcA(ALUSrcA_h),
      .ALUSrcB(ALUSrcB_h), .ALUOp(ALUOp_h), .PCSrc(PCSrc_h), .state(state_h), .fault(fault_h),
      .instr_done(done_h)
   );

   mc_control_fsm #(.MEM_TIMEOUT(16), .CNT_W(5), .HALT_ON_ILLEGAL(1'b0)) dut_n (
      .clk(clk), .reset(reset), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
      .PC_WE(PC_WE_n), .MemIn(MemIn_n), .Mem_WE(Mem_WE_n), .IR_WE(IR_WE_n), .Dst(Dst_n),
      .RegIn(RegIn_n), .Reg_WE(Reg_WE_n), .A_WE(A_WE_n), .B_WE(B_WE_n), .ALUSrcA(ALUSrcA_n),
      .ALUSrcB(ALUSrcB_n), .ALUOp(ALUOp_n), .PCSrc(PCSrc_n), .state(state_n), .fault(fault_n),
      .instr_done(done_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Move to the next cycle: pass a rising edge, then settle just after the falling edge.
   task automatic adv();
      @(negedge clk);
      #1;
   endtask

   initial begin
      reset       = 1'b1;
      instruction = 32'h0;
      zero        = 1'b0;
      mem_ready   = 1'b1;
      #1;
      chk("rst_state", 32'(state_h), 32'd0);
      chk("rst_fault", 32'(fault_h), 32'd0);
      chk("rst_ir_we_gated", 32'(IR_WE_h), 32'd0);
      chk("rst_pc_we_gated", 32'(PC_WE_h), 32'd0);
      adv();
      adv();

      // Fetch stall: IF holds without writing
      reset     = 1'b0;
      mem_ready = 1'b0;
      #1;
      chk("if_wait_ir_we", 32'(IR_WE_h), 32'd0);
      adv();
      chk("if_wait_state", 32'(state_h), 32'd0);

      // ADD $3,$1,$2
      instruction = 32'h00221820;
      mem_ready   = 1'b1;
      #1;
      chk("add_if_ir_we", 32'(IR_WE_h), 32'd1);
      chk("add_if_pc_we", 32'(PC_WE_h), 32'd1);
      chk("add_if_srcb", 32'(ALUSrcB_h), 32'd2);
      chk("add_if_pcsrc", 32'(PCSrc_h), 32'd2);
      adv();
      chk("add_id_state", 32'(state_h), 32'd1);
      chk("add_id_a_we", 32'(A_WE_h), 32'd1);
      chk("add_id_srcb", 32'(ALUSrcB_h), 32'd3);
      chk("add_id_done", 32'(done_h), 32'd0);
      adv();
      chk("add_ex_state", 32'(state_h), 32'd2);
      chk("add_ex_srca", 32'(ALUSrcA_h), 32'd1);
      chk("add_ex_aluop", 32'(ALUOp_h), 32'd0);
      chk("add_ex_done", 32'(done_h), 32'd0);
      adv();
      chk("add_wb_state", 32'(state_h), 32'd4);
      chk("add_wb_reg_we", 32'(Reg_WE_h), 32'd1);
      chk("add_wb_dst", 32'(Dst_h), 32'd0);
      chk("add_wb_regin", 32'(RegIn_h), 32'd0);
      chk("add_wb_done", 32'(done_h), 32'd1);
      adv();
      chk("add_end_state", 32'(state_h), 32'd0);

      // SLT $3,$1,$2
      instruction = 32'h0022182A;
      adv();
      adv();
      chk("slt_ex_aluop", 32'(ALUOp_h), 32'd3);
      adv();
      adv();
      chk("slt_end_state", 32'(state_h), 32'd0);

      // LW $5,8($4) with three stalled MEM cycles
      instruction = 32'h8C850008;
      adv();
      adv();
      chk("lw_ex_srcb", 32'(ALUSrcB_h), 32'd1);
      mem_ready = 1'b0;
      adv();
      for (int i = 0; i < 3; i++) begin
         chk("lw_mem_state", 32'(state_h), 32'd3);
         chk("lw_mem_memin", 32'(MemIn_h), 32'd1);
         chk("lw_mem_we", 32'(Mem_WE_h), 32'd0);
         adv();
      end
      mem_ready = 1'b1;
      #1;
      chk("lw_mem4_state", 32'(state_h), 32'd3);
      chk("lw_mem4_we", 32'(Mem_WE_h), 32'd0);
      chk("lw_mem4_done", 32'(done_h), 32'd0);
      adv();
      chk("lw_wb_state", 32'(state_h), 32'd4);
      chk("lw_wb_dst", 32'(Dst_h), 32'd1);
      chk("lw_wb_regin", 32'(RegIn_h), 32'd1);
      chk("lw_wb_done", 32'(done_h), 32'd1);
      adv();
      chk("lw_end_state", 32'(state_h), 32'd0);

      // BEQ taken
      instruction = 32'h10220004;
      zero        = 1'b1;
      adv();
      adv();
      chk("beq_ex_pc_we", 32'(PC_WE_h), 32'd1);
      chk("beq_ex_pcsrc", 32'(PCSrc_h), 32'd0);
      chk("beq_ex_aluop", 32'(ALUOp_h), 32'd1);
      chk("beq_ex_done", 32'(done_h), 32'd1);
      adv();
      chk("beq_end_state", 32'(state_h), 32'd0);

      // BNE not taken
      instruction = 32'h14220004;
      adv();
      adv();
      chk("bne_ex_pc_we", 32'(PC_WE_h), 32'd0);
      chk("bne_ex_done", 32'(done_h), 32'd1);
      adv();
      chk("bne_end_state", 32'(state_h), 32'd0);
      zero = 1'b0;

      // JAL
      instruction = 32'h0C000010;
      adv();
      chk("jal_id_pc_we", 32'(PC_WE_h), 32'd1);
      chk("jal_id_pcsrc", 32'(PCSrc_h), 32'd1);
      chk("jal_id_reg_we", 32'(Reg_WE_h), 32'd1);
      chk("jal_id_dst", 32'(Dst_h), 32'd2);
      chk("jal_id_regin", 32'(RegIn_h), 32'd2);
      chk("jal_id_done", 32'(done_h), 32'd1);
      adv();
      chk("jal_end_state", 32'(state_h), 32'd0);

      // JR $31
      instruction = 32'h03E00008;
      adv();
      adv();
      chk("jr_ex_pc_we", 32'(PC_WE_h), 32'd1);
      chk("jr_ex_pcsrc", 32'(PCSrc_h), 32'd3);
      adv();
      chk("jr_end_state", 32'(state_h), 32'd0);

      // SW where mem_ready arrives on the very last allowed cycle
      instruction = 32'hAC850008;
      adv();
      adv();
      mem_ready = 1'b0;
      adv();
      for (int i = 0; i < 15; i++) adv();
      mem_ready = 1'b1;
      #1;
      chk("sw_lim_state", 32'(state_h), 32'd3);
      chk("sw_lim_mem_we", 32'(Mem_WE_h), 32'd1);
      chk("sw_lim_done", 32'(done_h), 32'd1);
      adv();
      chk("sw_lim_end_state", 32'(state_h), 32'd0);
      chk("sw_lim_fault", 32'(fault_h), 32'd0);

      // SW with mem_ready stuck low: timeout to ERR
      adv();
      adv();
      mem_ready = 1'b0;
      adv();
      for (int i = 0; i < 16; i++) begin
         chk("sw_to_state", 32'(state_h), 32'd3);
         chk("sw_to_mem_we", 32'(Mem_WE_h), 32'd1);
         adv();
      end
      chk("err_state", 32'(state_h), 32'd7);
      chk("err_fault", 32'(fault_h), 32'd1);
      chk("err_mem_we", 32'(Mem_WE_h), 32'd0);
      mem_ready = 1'b1;
      #1;
      chk("err_ir_we", 32'(IR_WE_h), 32'd0);
      chk("err_pc_we", 32'(PC_WE_h), 32'd0);
      adv();
      chk("err_hold_state", 32'(state_h), 32'd7);

      // Asynchronous reset out of ERR
      reset = 1'b1;
      #1;
      chk("rst_err_state", 32'(state_h), 32'd0);
      chk("rst_err_fault", 32'(fault_h), 32'd0);
      adv();
      reset = 1'b0;

      // Illegal opcode 0x3F on both instances
      instruction = 32'hFC000000;
      adv();
      chk("ill_h_id_state", 32'(state_h), 32'd1);
      chk("ill_h_id_done", 32'(done_h), 32'd0);
      chk("ill_n_id_done", 32'(done_n), 32'd1);
      chk("ill_n_id_reg_we", 32'(Reg_WE_n), 32'd0);
      chk("ill_n_id_mem_we", 32'(Mem_WE_n), 32'd0);
      adv();
      chk("ill_h_state", 32'(state_h), 32'd7);
      chk("ill_h_fault", 32'(fault_h), 32'd1);
      chk("ill_n_state", 32'(state_n), 32'd0);
      chk("ill_n_fault", 32'(fault_n), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
